// File: rtl/axis_maxpool_2x2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_maxpool_2x2_pkg
//  Description : Shared constants, FSM encoding and signed lane-max helper
//                for the 2x2/stride-2 AXI-Stream max-pool stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_maxpool_2x2_pkg;

    localparam int WORD_WIDTH = 8;
    localparam int LANES      = 32;
    localparam int MAX_COLS   = 384;
    localparam int BITS_COLS  = $clog2(MAX_COLS + 1);

    localparam int c_BEAT_W   = LANES * WORD_WIDTH;
    localparam int c_LB_DEPTH = MAX_COLS / 2;
    // Line-buffer address is the pixel column with its LSB dropped.
    localparam int c_LB_AW    = BITS_COLS - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYPASS = 2'd1,
        ST_POOL   = 2'd2
    } state_t;

    // Lane-wise signed maximum of two beats.
    function automatic logic [c_BEAT_W-1:0] lane_max(
        input logic [c_BEAT_W-1:0] a,
        input logic [c_BEAT_W-1:0] b
    );
        logic [c_BEAT_W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            if ($signed(a[l*WORD_WIDTH +: WORD_WIDTH]) > $signed(b[l*WORD_WIDTH +: WORD_WIDTH]))
                r[l*WORD_WIDTH +: WORD_WIDTH] = a[l*WORD_WIDTH +: WORD_WIDTH];
            else
                r[l*WORD_WIDTH +: WORD_WIDTH] = b[l*WORD_WIDTH +: WORD_WIDTH];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : maxpool_line_buffer
//  Description : Simple-dual-port register array holding the horizontal
//                pair maxima of the even row; async read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module maxpool_line_buffer #(
    parameter int DEPTH  = 192,
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents need no reset since every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axis_maxpool_2x2.sv
`default_nettype none
// ============================================================================
//  Module      : axis_maxpool_2x2
//  Description : 2x2/stride-2 signed max-pool over a raster AXI-Stream pixel
//                stream, with per-frame bypass and sticky framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_maxpool_2x2
    import axis_maxpool_2x2_pkg::*;
(
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [BITS_COLS-1:0] cfg_cols,
    input  logic                 cfg_pool_en,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [c_BEAT_W-1:0]  s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [c_BEAT_W-1:0]  m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 err_frame
);

    state_t                r_state;
    logic [BITS_COLS-1:0]  r_cols;
    logic [BITS_COLS-1:0]  r_col;
    logic                  r_row_odd;
    logic [c_BEAT_W-1:0]   r_hold;
    logic                  r_m_valid;
    logic [c_BEAT_W-1:0]   r_m_data;
    logic                  r_m_last;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_pool_mode;
    logic [BITS_COLS-1:0]  w_cols;
    logic                  w_col_odd;
    logic                  w_col_last;
    logic                  w_bad_last;
    logic                  w_pool_emit;
    logic                  w_lb_we;
    logic [c_LB_AW-1:0]    w_lb_addr;
    logic [c_BEAT_W-1:0]   w_lb_rdata;
    logic [c_BEAT_W-1:0]   w_hmax;
    logic [c_BEAT_W-1:0]   w_pool_out;

    assign w_ready     = ~r_m_valid | m_axis_tready;
    assign w_accept    = s_axis_tvalid & w_ready;

    // In IDLE the incoming beat is the first of a frame, so it is decoded
    // with the live config; col/row_odd are already zero there.
    assign w_pool_mode = (r_state == ST_IDLE) ? cfg_pool_en : (r_state == ST_POOL);
    assign w_cols      = (r_state == ST_IDLE) ? cfg_cols : r_cols;

    assign w_col_odd   = r_col[0];
    assign w_col_last  = (r_col == w_cols - BITS_COLS'(1));
    assign w_bad_last  = s_axis_tlast & ~(w_col_last & r_row_odd);

    assign w_hmax      = lane_max(r_hold, s_axis_tdata);
    assign w_pool_out  = lane_max(w_lb_rdata, w_hmax);
    assign w_lb_addr   = r_col[BITS_COLS-1:1];
    assign w_lb_we     = w_accept & w_pool_mode & w_col_odd & ~r_row_odd & ~w_bad_last;
    assign w_pool_emit = w_accept & w_pool_mode & w_col_odd &  r_row_odd & ~w_bad_last;

    maxpool_line_buffer #(
        .DEPTH  (c_LB_DEPTH),
        .WIDTH  (c_BEAT_W),
        .ADDR_W (c_LB_AW)
    ) u_line_buffer (
        .clk     (aclk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_hmax),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    // Frame FSM, raster counters, hold register and single-stage output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_cols    <= '0;
            r_col     <= '0;
            r_row_odd <= 1'b0;
            r_hold    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_m_valid && m_axis_tready)
                r_m_valid <= 1'b0;

            if (w_accept) begin
                if (!w_pool_mode) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= s_axis_tdata;
                    r_m_last  <= s_axis_tlast;
                    r_state   <= s_axis_tlast ? ST_IDLE : ST_BYPASS;
                end else begin
                    if (r_state == ST_IDLE)
                        r_cols <= cfg_cols;
                    if (!w_col_odd)
                        r_hold <= s_axis_tdata;
                    if (w_pool_emit) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_pool_out;
                        r_m_last  <= s_axis_tlast;
                    end
                    if (s_axis_tlast) begin
                        // Legal or not, tlast ends the frame; a misplaced one
                        // simply abandons the partial window.
                        if (w_bad_last)
                            r_err <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_col     <= '0;
                        r_row_odd <= 1'b0;
                    end else begin
                        r_state <= ST_POOL;
                        if (w_col_last) begin
                            r_col     <= '0;
                            r_row_odd <= ~r_row_odd;
                        end else begin
                            r_col <= r_col + BITS_COLS'(1);
                        end
                    end
                end
            end
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign err_frame     = r_err;

endmodule
`default_nettype wire
